// File: rtl/pong_input_cond.sv
// Button conditioning for pong: 2-FF sync and per-bit debounce, serve pulses,
// and per-frame paddle deltas latched on the falling edge of vsync.
module pong_input_cond #(
   parameter int unsigned DB_LIMIT = 250000,
   parameter int unsigned DB_W     = $clog2(DB_LIMIT)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] btn_raw_i,
   input  logic       vsync_i,
   output logic [5:0] btn_level_o,
   output logic [1:0] p1_delta_o,
   output logic [1:0] p2_delta_o,
   output logic [1:0] srv_pulse_o,
   output logic       frame_stb_o
);

   localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_LIMIT - 1);

   logic [5:0]      s1_q, s2_q;
   logic [5:0]      db_q, db_d;
   logic [DB_W-1:0] cnt_q [6];
   logic [DB_W-1:0] cnt_d [6];
   logic [1:0]      srv_q, srv_d;
   logic            vsync_prev_q;
   logic            frame_edge;
   logic [1:0]      p1_q, p1_d;
   logic [1:0]      p2_q, p2_d;
   logic            stb_q, stb_d;

   function automatic logic [1:0] enc_delta(input logic up, input logic dn);
      logic [1:0] d;
      unique case ({up, dn})
         2'b10:   d = 2'b01;
         2'b01:   d = 2'b11;
         default: d = 2'b00;
      endcase
      return d;
   endfunction

   always_comb begin
      db_d = db_q;
      for (int unsigned i = 0; i < 6; i++) begin
         cnt_d[i] = '0;
         if (s2_q[i] != db_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               db_d[i] = s2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end

      srv_d = {db_d[5] & ~db_q[5], db_d[2] & ~db_q[2]};

      // Latch samples db_q, so a coincident debounce update shows up next frame
      frame_edge = vsync_prev_q & ~vsync_i;
      p1_d  = frame_edge ? enc_delta(db_q[0], db_q[1]) : p1_q;
      p2_d  = frame_edge ? enc_delta(db_q[3], db_q[4]) : p2_q;
      stb_d = frame_edge;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q         <= '0;
         s2_q         <= '0;
         db_q         <= '0;
         for (int unsigned i = 0; i < 6; i++) begin
            cnt_q[i] <= '0;
         end
         srv_q        <= '0;
         vsync_prev_q <= 1'b0;
         p1_q         <= '0;
         p2_q         <= '0;
         stb_q        <= 1'b0;
      end else begin
         s1_q         <= btn_raw_i;
         s2_q         <= s1_q;
         db_q         <= db_d;
         for (int unsigned i = 0; i < 6; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         srv_q        <= srv_d;
         vsync_prev_q <= vsync_i;
         p1_q         <= p1_d;
         p2_q         <= p2_d;
         stb_q        <= stb_d;
      end
   end

   assign btn_level_o = db_q;
   assign p1_delta_o  = p1_q;
   assign p2_delta_o  = p2_q;
   assign srv_pulse_o = srv_q;
   assign frame_stb_o = stb_q;

endmodule

// File: tb/tb_pong_input_cond.sv
// Scoreboard bench for pong_input_cond with DB_LIMIT=4: expectations are queued
// with their due cycle when stimulus is driven and compared at that cycle.
module tb_pong_input_cond;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] btn_raw;
   logic       vsync;
   logic [5:0] btn_level;
   logic [1:0] p1_delta, p2_delta, srv_pulse;
   logic       frame_stb;

   pong_input_cond #(.DB_LIMIT(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_raw_i   (btn_raw),
      .vsync_i     (vsync),
      .btn_level_o (btn_level),
      .p1_delta_o  (p1_delta),
      .p2_delta_o  (p2_delta),
      .srv_pulse_o (srv_pulse),
      .frame_stb_o (frame_stb)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Observation word: {level[5:0], p1[1:0], p2[1:0], srv[1:0], stb}
   logic [12:0] obs;
   assign obs = {btn_level, p1_delta, p2_delta, srv_pulse, frame_stb};

   typedef struct {
      int unsigned cyc;
      logic [12:0] mask;
      logic [12:0] val;
      string       name;
   } exp_t;
   exp_t exp_q[$];

   int unsigned total = 0;
   int unsigned bad   = 0;

   function automatic logic [12:0] F_LVL(input logic [5:0] v); return {v, 7'd0};        endfunction
   function automatic logic [12:0] F_P1 (input logic [1:0] v); return {6'd0, v, 5'd0};  endfunction
   function automatic logic [12:0] F_P2 (input logic [1:0] v); return {8'd0, v, 3'd0};  endfunction
   function automatic logic [12:0] F_SRV(input logic [1:0] v); return {10'd0, v, 1'b0}; endfunction
   function automatic logic [12:0] F_STB(input logic v);       return {12'd0, v};       endfunction

   task automatic sb_push(input int unsigned c, input logic [12:0] m, input logic [12:0] v,
                          input string n);
      exp_t e;
      e.cyc = c; e.mask = m; e.val = v; e.name = n;
      exp_q.push_back(e);
   endtask

   task automatic test_reset;
      int unsigned base;
      base = cyc;
      for (int unsigned o = 0; o < 4; o++) sb_push(base + o, 13'h1FFF, 13'h0, "reset_zero");
      sb_push(base + 9,  F_LVL(6'h3F), F_LVL(6'h00), "rst_lvl_early");
      sb_push(base + 10, F_LVL(6'h3F), F_LVL(6'h3F), "rst_lvl");
      sb_push(base + 9,  F_SRV(2'b11), F_SRV(2'b00), "rst_srv_early");
      sb_push(base + 10, F_SRV(2'b11), F_SRV(2'b11), "rst_srv");
      sb_push(base + 11, F_SRV(2'b11), F_SRV(2'b00), "rst_srv_once");
      sb_push(base + 19, F_LVL(6'h3F), F_LVL(6'h3F), "release_lvl_hold");
      sb_push(base + 20, F_LVL(6'h3F), F_LVL(6'h00), "release_lvl");
      for (int unsigned o = 15; o < 23; o++) sb_push(base + o, F_SRV(2'b11), 13'h0, "release_no_srv");
      for (int unsigned k = 0; k < 24; k++) begin
         for (int i = int'(exp_q.size()) - 1; i >= 0; i--) begin
            if (exp_q[i].cyc == cyc) begin
               total++;
               if ((obs & exp_q[i].mask) !== exp_q[i].val) begin
                  bad++;
                  $display("FAIL %s cyc=%0d got=%h exp=%h", exp_q[i].name, cyc, obs & exp_q[i].mask, exp_q[i].val);
               end
               exp_q.delete(i);
            end
         end
         if (k == 4)  rst_n = 1'b1;
         if (k == 14) btn_raw = 6'h00;
         @(negedge clk);
      end
   endtask

   task automatic test_glitch;
      int unsigned base;
      base = cyc;
      for (int unsigned o = 1; o < 13; o++) sb_push(base + o, F_LVL(6'h01), 13'h0, "glitch_lvl");
      sb_push(base + 17, F_LVL(6'h01), F_LVL(6'h00), "hold_lvl_early");
      sb_push(base + 18, F_LVL(6'h01), F_LVL(6'h01), "hold_lvl");
      for (int unsigned k = 0; k < 20; k++) begin
         for (int i = int'(exp_q.size()) - 1; i >= 0; i--) begin
            if (exp_q[i].cyc == cyc) begin
               total++;
               if ((obs & exp_q[i].mask) !== exp_q[i].val) begin
                  bad++;
                  $display("FAIL %s cyc=%0d got=%h exp=%h", exp_q[i].name, cyc, obs & exp_q[i].mask, exp_q[i].val);
               end
               exp_q.delete(i);
            end
         end
         if (k == 8) begin
            total++;
            if (dut.cnt_q[0] !== 2'd0) begin
               bad++;
               $display("FAIL glitch_cnt got=%0d exp=0", dut.cnt_q[0]);
            end
         end
         if (k == 0)  btn_raw[0] = 1'b1;
         if (k == 3)  btn_raw[0] = 1'b0;
         if (k == 12) btn_raw[0] = 1'b1;
         @(negedge clk);
      end
   endtask

   task automatic test_frame;
      logic [5:0]  pats [3];
      logic [1:0]  e1   [3];
      logic [1:0]  e2   [3];
      logic [1:0]  prev1, prev2;
      int unsigned bj;
      pats[0] = 6'h01; e1[0] = 2'b01; e2[0] = 2'b00;
      pats[1] = 6'h03; e1[1] = 2'b00; e2[1] = 2'b00;
      pats[2] = 6'h10; e1[2] = 2'b00; e2[2] = 2'b11;
      prev1 = 2'b00; prev2 = 2'b00;
      for (int unsigned k = 0; k < 42; k++) begin
         if (k % 14 == 0) begin
            bj = cyc;
            sb_push(bj + 6,  F_LVL(6'h13), F_LVL(pats[k/14]), "frame_lvl");
            sb_push(bj + 10, F_P1(2'b11) | F_P2(2'b11) | F_STB(1'b1),
                    F_P1(prev1) | F_P2(prev2), "frame_hold_before");
            sb_push(bj + 11, F_P1(2'b11) | F_P2(2'b11) | F_STB(1'b1),
                    F_P1(e1[k/14]) | F_P2(e2[k/14]) | F_STB(1'b1), "frame_latch");
            sb_push(bj + 12, F_STB(1'b1), F_STB(1'b0), "frame_stb_drop");
            sb_push(bj + 13, F_P1(2'b11) | F_P2(2'b11) | F_STB(1'b1),
                    F_P1(e1[k/14]) | F_P2(e2[k/14]), "frame_hold_low");
            prev1 = e1[k/14]; prev2 = e2[k/14];
         end
         for (int i = int'(exp_q.size()) - 1; i >= 0; i--) begin
            if (exp_q[i].cyc == cyc) begin
               total++;
               if ((obs & exp_q[i].mask) !== exp_q[i].val) begin
                  bad++;
                  $display("FAIL %s cyc=%0d got=%h exp=%h", exp_q[i].name, cyc, obs & exp_q[i].mask, exp_q[i].val);
               end
               exp_q.delete(i);
            end
         end
         if (k % 14 == 0)  btn_raw = pats[k/14];
         if (k % 14 == 8)  vsync = 1'b1;
         if (k % 14 == 10) vsync = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_serve;
      int unsigned base;
      base = cyc;
      for (int unsigned o = 0; o < 10; o++)  sb_push(base + o, F_SRV(2'b11), 13'h0, "srv_quiet");
      sb_push(base + 15, F_SRV(2'b11), F_SRV(2'b00), "srv_p1_early");
      sb_push(base + 16, F_SRV(2'b11), F_SRV(2'b01), "srv_p1");
      sb_push(base + 16, F_LVL(6'h04), F_LVL(6'h04), "srv_p1_lvl");
      for (int unsigned o = 17; o < 41; o++) sb_push(base + o, F_SRV(2'b11), 13'h0, "srv_single");
      sb_push(base + 36, F_LVL(6'h04), F_LVL(6'h00), "srv_release_lvl");
      sb_push(base + 47, F_SRV(2'b11), F_SRV(2'b00), "srv_both_early");
      sb_push(base + 48, F_SRV(2'b11), F_SRV(2'b11), "srv_both");
      sb_push(base + 49, F_SRV(2'b11), F_SRV(2'b00), "srv_both_once");
      for (int unsigned o = 53; o < 61; o++) sb_push(base + o, F_SRV(2'b11), 13'h0, "srv_both_release");
      for (int unsigned k = 0; k < 62; k++) begin
         for (int i = int'(exp_q.size()) - 1; i >= 0; i--) begin
            if (exp_q[i].cyc == cyc) begin
               total++;
               if ((obs & exp_q[i].mask) !== exp_q[i].val) begin
                  bad++;
                  $display("FAIL %s cyc=%0d got=%h exp=%h", exp_q[i].name, cyc, obs & exp_q[i].mask, exp_q[i].val);
               end
               exp_q.delete(i);
            end
         end
         if (k == 0)  btn_raw = 6'h00;
         if (k == 10) btn_raw = 6'h04;
         if (k == 30) btn_raw = 6'h00;
         if (k == 42) btn_raw = 6'h24;
         if (k == 52) btn_raw = 6'h00;
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid;
      int unsigned base;
      base = cyc;
      sb_push(base + 5,  13'h1FFF, 13'h0, "mid_reset_zero");
      sb_push(base + 10, F_LVL(6'h02), F_LVL(6'h00), "mid_relatch_early");
      sb_push(base + 11, F_LVL(6'h02), F_LVL(6'h02), "mid_relatch");
      sb_push(base + 20, F_LVL(6'h02), F_LVL(6'h00), "mid_release");
      for (int unsigned k = 0; k < 22; k++) begin
         for (int i = int'(exp_q.size()) - 1; i >= 0; i--) begin
            if (exp_q[i].cyc == cyc) begin
               total++;
               if ((obs & exp_q[i].mask) !== exp_q[i].val) begin
                  bad++;
                  $display("FAIL %s cyc=%0d got=%h exp=%h", exp_q[i].name, cyc, obs & exp_q[i].mask, exp_q[i].val);
               end
               exp_q.delete(i);
            end
         end
         if (k == 4) begin
            total++;
            if (dut.cnt_q[1] !== 2'd2) begin
               bad++;
               $display("FAIL mid_cnt got=%0d exp=2", dut.cnt_q[1]);
            end
         end
         if (k == 8) begin
            total++;
            if (dut.cnt_q[1] !== 2'd1) begin
               bad++;
               $display("FAIL mid_cnt_restart got=%0d exp=1", dut.cnt_q[1]);
            end
         end
         if (k == 0)  btn_raw = 6'h02;
         if (k == 4)  rst_n = 1'b0;
         if (k == 5)  rst_n = 1'b1;
         if (k == 14) btn_raw = 6'h00;
         @(negedge clk);
      end
   endtask

   task automatic test_coincident;
      int unsigned base;
      base = cyc;
      sb_push(base + 5,  F_LVL(6'h01), F_LVL(6'h00), "coinc_lvl_early");
      sb_push(base + 6,  F_LVL(6'h01) | F_P1(2'b11) | F_STB(1'b1),
              F_LVL(6'h01) | F_P1(2'b00) | F_STB(1'b1), "coinc_old");
      sb_push(base + 10, F_P1(2'b11) | F_STB(1'b1), F_P1(2'b00), "coinc_hold");
      sb_push(base + 11, F_P1(2'b11) | F_STB(1'b1), F_P1(2'b01) | F_STB(1'b1), "coinc_new");
      for (int unsigned k = 0; k < 14; k++) begin
         for (int i = int'(exp_q.size()) - 1; i >= 0; i--) begin
            if (exp_q[i].cyc == cyc) begin
               total++;
               if ((obs & exp_q[i].mask) !== exp_q[i].val) begin
                  bad++;
                  $display("FAIL %s cyc=%0d got=%h exp=%h", exp_q[i].name, cyc, obs & exp_q[i].mask, exp_q[i].val);
               end
               exp_q.delete(i);
            end
         end
         if (k == 0)  btn_raw = 6'h01;
         if (k == 3)  vsync = 1'b1;
         if (k == 5)  vsync = 1'b0;
         if (k == 8)  vsync = 1'b1;
         if (k == 10) vsync = 1'b0;
         @(negedge clk);
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      btn_raw = 6'h3F;
      vsync   = 1'b0;
      @(negedge clk);
      test_reset();
      test_glitch();
      test_frame();
      test_serve();
      test_reset_mid();
      test_coincident();
      while (exp_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL %s unchecked due_cyc=%0d now=%0d", exp_q[0].name, exp_q[0].cyc, cyc);
         void'(exp_q.pop_front());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
